// File: rtl/io_uart_pkg.sv
// io_uart_pkg: shared encodings, status layout and line levels for the io_uart_tx transmitter.
package io_uart_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_IDX_W = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } uart_state_e;

    // Bit positions inside the status byte read back by software.
    localparam int unsigned ST_EMPTY = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_BUSY  = 2;
    localparam int unsigned ST_OVR   = 3;

    typedef struct packed {
        logic [3:0] rsvd;
        logic       overrun;
        logic       busy;
        logic       fifo_full;
        logic       fifo_empty;
    } uart_status_t;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/io_uart_tx_if.sv
// io_uart_tx_if: IO-unit side of the transmitter (write strobe, overrun clear, status and serial line).
interface io_uart_tx_if;
    import io_uart_pkg::*;

    logic              wr_en;
    logic [BYTE_W-1:0] wr_data;
    logic              clr_ovr;
    logic              txd;
    logic [BYTE_W-1:0] status;
    logic              tx_done;

    modport master (
        output wr_en, wr_data, clr_ovr,
        input  txd, status, tx_done
    );

    modport slave (
        input  wr_en, wr_data, clr_ovr,
        output txd, status, tx_done
    );
endinterface

// File: rtl/io_sync_fifo.sv
// io_sync_fifo: single-clock FIFO with a combinational head output; pushes while full and pops while empty are ignored.
module io_sync_fifo
    import io_uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CNTW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CNTW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNTW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNTW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end
endmodule

// File: rtl/io_uart_tx.sv
// io_uart_tx: FIFO-buffered serial transmitter (8N1, LSB first) fed by the CPU IO port unit.
// Build option IO_UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module io_uart_tx
    import io_uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic         clk,
    input logic         reset,
    io_uart_tx_if.slave bus
);
    localparam int unsigned CW = $clog2(CLK_DIV);

    uart_state_e           state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BIT_IDX_W-1:0]  bit_q, bit_d;
    logic [BYTE_W-1:0]     shift_q, shift_d;
    logic                  txd_q, txd_d;
    logic                  tx_done_q, tx_done_d;
    logic                  overrun_q, overrun_d;
`ifdef IO_UART_TX_PARITY_EN
    logic                  par_q, par_d;
`endif

    logic                  baud_last;
    logic                  load;
    logic                  fifo_pop;
    logic [BYTE_W-1:0]     fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    uart_status_t          status_c;

    io_sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.wr_en),
        .pop   (fifo_pop),
        .din   (bus.wr_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign baud_last = (cnt_q == CW'(CLK_DIV - 1));

    // A write that finds the FIFO full sets overrun even when clr_ovr arrives in the same cycle.
    assign overrun_d = (bus.wr_en & fifo_full) | (overrun_q & ~bus.clr_ovr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            txd_q     <= IDLE_LVL;
            tx_done_q <= 1'b0;
            overrun_q <= 1'b0;
`ifdef IO_UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            tx_done_q <= tx_done_d;
            overrun_q <= overrun_d;
`ifdef IO_UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        load     = 1'b0;
        fifo_pop = 1'b0;
        txd_d    = IDLE_LVL;
`ifdef IO_UART_TX_PARITY_EN
        par_d    = par_q;
`endif

        if (state_q != IDLE) begin
            cnt_d = baud_last ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                load = ~fifo_empty;
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_IDX_W'(7)) begin
`ifdef IO_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_IDX_W'(1);
                    end
                end
            end
`ifdef IO_UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_last) begin
                    state_d = IDLE;
                    load    = ~fifo_empty;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Loading from IDLE or the last stop cycle gives back-to-back frames with no idle gap.
        if (load) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            cnt_d    = '0;
            bit_d    = '0;
            state_d  = START;
`ifdef IO_UART_TX_PARITY_EN
            par_d    = ^fifo_dout;
`endif
        end

        case (state_d)
            START:   txd_d = START_LVL;
            DATA:    txd_d = shift_d[0];
`ifdef IO_UART_TX_PARITY_EN
            PARITY:  txd_d = par_d;
`endif
            default: txd_d = IDLE_LVL;
        endcase

        tx_done_d = (state_d == STOP) && (cnt_d == CW'(CLK_DIV - 1));
    end

    always_comb begin
        status_c            = '0;
        status_c.overrun    = overrun_q;
        status_c.busy       = (state_q != IDLE) | ~fifo_empty;
        status_c.fifo_full  = fifo_full;
        status_c.fifo_empty = fifo_empty;
    end

    assign bus.txd     = txd_q;
    assign bus.tx_done = tx_done_q;
    assign bus.status  = status_c;
endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: directed, table-driven bench for io_uart_tx plus burst, overrun and reset sequences.
`timescale 1ns/1ps
module tb_io_uart_tx;
    import io_uart_pkg::*;

`ifdef IO_UART_TX_PARITY_EN
    localparam int unsigned CD = 2;
    localparam int unsigned NB = 11;
`else
    localparam int unsigned CD = 4;
    localparam int unsigned NB = 10;
`endif
    localparam int unsigned FL    = NB * CD;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [7:0] data;
        logic [9:0] slots;
        logic       par;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    io_uart_tx_if bus();

    io_uart_tx #(
        .CLK_DIV    (CD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serial line decoder used during the burst test.
    logic        mon_en = 1'b0;
    bit          rx_act = 1'b0;
    int unsigned rx_cyc = 0;
    int unsigned slot;
    int unsigned cyc = 0;
    logic [7:0]  rx_byte = '0;
    logic [7:0]  exp_q[$];
    int unsigned done_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (reset || !mon_en) begin
            rx_act = 1'b0;
        end else begin
            if (bus.tx_done) done_cyc.push_back(cyc);
            if (!rx_act) begin
                if (bus.txd == 1'b0) begin
                    rx_act = 1'b1;
                    rx_cyc = 0;
                end
            end else begin
                rx_cyc++;
            end
            if (rx_act && (rx_cyc % CD) == CD / 2) begin
                slot = rx_cyc / CD;
                if (slot >= 1 && slot <= 8) rx_byte[slot-1] = bus.txd;
`ifdef IO_UART_TX_PARITY_EN
                if (slot == 9) check("rx_parity", 32'(bus.txd), 32'(^rx_byte));
`endif
                if (slot == NB - 1) begin
                    rx_act = 1'b0;
                    check("rx_stop", 32'(bus.txd), 32'd1);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rx_extra: got frame %02h expected none", rx_byte);
                    end else begin
                        check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    // One frame from an idle, empty transmitter; checks latency, bit levels, tx_done timing and final status.
    task automatic run_vec(input vec_t v);
        logic [10:0] got;
        logic [10:0] exp_full;
        int          ndone;
        int          done_at;
        got     = '0;
        ndone   = 0;
        done_at = -1;
`ifdef IO_UART_TX_PARITY_EN
        exp_full = {1'b1, v.par, v.slots[8:0]};
`else
        exp_full = {1'b0, v.slots};
`endif
        bus.wr_en   = 1'b1;
        bus.wr_data = v.data;
        tick();
        bus.wr_en = 1'b0;
        check("status_after_push", 32'(bus.status), 32'h04);
        for (int unsigned k = 0; k < FL; k++) begin
            tick();
            if (k == 0) check("start_latency", 32'(bus.txd), 32'd0);
            if ((k % CD) == CD / 2) got[k/CD] = bus.txd;
            if (bus.tx_done) begin
                ndone++;
                done_at = int'(k) + 1;
            end
        end
        check("frame_bits", 32'(got), 32'(exp_full));
        check("tx_done_count", 32'(ndone), 32'd1);
        check("tx_done_cycle", 32'(done_at), 32'(FL));
        tick();
        check("idle_txd", 32'(bus.txd), 32'd1);
        check("idle_tx_done", 32'(bus.tx_done), 32'd0);
        check("final_status", 32'(bus.status), 32'h01);
    endtask

    vec_t vecs[6];
    int   bad;
    int   to;

    initial begin
        vecs[0] = '{data: 8'hA5, slots: 10'b1_1010_0101_0, par: 1'b0};
        vecs[1] = '{data: 8'h07, slots: 10'b1_0000_0111_0, par: 1'b1};
        vecs[2] = '{data: 8'h00, slots: 10'b1_0000_0000_0, par: 1'b0};
        vecs[3] = '{data: 8'hFF, slots: 10'b1_1111_1111_0, par: 1'b0};
        vecs[4] = '{data: 8'h80, slots: 10'b1_1000_0000_0, par: 1'b1};
        vecs[5] = '{data: 8'h3C, slots: 10'b1_0011_1100_0, par: 1'b0};

        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.clr_ovr = 1'b0;
        reset       = 1'b1;
        tick();
        tick();
        check("reset_txd", 32'(bus.txd), 32'd1);
        check("reset_status", 32'(bus.status), 32'h01);
        check("reset_tx_done", 32'(bus.tx_done), 32'd0);
        reset = 1'b0;

        bad = 0;
        repeat (50) begin
            tick();
            if (bus.txd !== 1'b1 || bus.tx_done !== 1'b0) bad++;
        end
        check("idle_50_cycles", 32'(bad), 32'd0);
        check("idle_status", 32'(bus.status), 32'h01);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Burst: fill, overflow, clear, drop-on-pop, and set-wins-over-clear.
        exp_q  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h88};
        mon_en = 1'b1;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h11; tick();
        bus.wr_data = 8'h22; tick();
        bus.wr_data = 8'h33; tick();
        bus.wr_data = 8'h44; tick();
        bus.wr_data = 8'h55; tick();
        check("burst_full", 32'(bus.status), 32'h06);
        bus.wr_data = 8'h66; tick();
        check("burst_overrun", 32'(bus.status), 32'h0E);
        bus.wr_en   = 1'b0;
        bus.clr_ovr = 1'b1; tick();
        bus.clr_ovr = 1'b0;
        check("clr_ovr", 32'(bus.status), 32'h06);

        to = 0;
        while (!bus.tx_done && to < int'(2 * FL)) begin
            tick();
            to++;
        end
        check("wait_first_done", 32'(bus.tx_done), 32'd1);
        bus.wr_en = 1'b1; bus.wr_data = 8'h77; tick();
        check("drop_with_pop", 32'(bus.status), 32'h0C);
        bus.wr_data = 8'h88; tick();
        check("refill_full", 32'(bus.status), 32'h0E);
        bus.wr_data = 8'h99; bus.clr_ovr = 1'b1; tick();
        check("set_wins_over_clr", 32'(bus.status), 32'h0E);
        bus.wr_en = 1'b0; tick();
        bus.clr_ovr = 1'b0;
        check("clr_after_set", 32'(bus.status), 32'h06);

        to = 0;
        while (bus.status !== 8'h01 && to < int'(8 * FL)) begin
            tick();
            to++;
        end
        check("burst_drain", 32'(bus.status), 32'h01);
        tick();
        tick();
        check("burst_frames_left", 32'(exp_q.size()), 32'd0);
        check("burst_done_count", 32'(done_cyc.size()), 32'd6);
        for (int i = 1; i < done_cyc.size(); i++)
            check("burst_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 32'(FL));
        mon_en = 1'b0;

        // Reset mid-DATA of 8'hFF: line high at once, FIFO empty, no tx_done afterwards.
        bus.wr_en = 1'b1; bus.wr_data = 8'hFF; tick();
        bus.wr_en = 1'b0;
        repeat (4 * CD) tick();
        reset = 1'b1;
        #1;
        check("rst_mid_data_txd", 32'(bus.txd), 32'd1);
        check("rst_mid_data_status", 32'(bus.status), 32'h01);
        tick();
        reset = 1'b0;
        bad = 0;
        repeat (2 * FL) begin
            tick();
            if (bus.tx_done !== 1'b0 || bus.txd !== 1'b1) bad++;
        end
        check("no_activity_after_reset", 32'(bad), 32'd0);

        // Reset during START must raise the line before the next clock edge.
        bus.wr_en = 1'b1; bus.wr_data = 8'h00; tick();
        bus.wr_en = 1'b0;
        tick();
        check("pre_reset_start", 32'(bus.txd), 32'd0);
        reset = 1'b1;
        #1;
        check("rst_in_start_txd", 32'(bus.txd), 32'd1);
        tick();
        reset = 1'b0;
        tick();

        run_vec('{data: 8'h0F, slots: 10'b1_0000_1111_0, par: 1'b0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
- Serial transmitter that sits directly downstream of the CPU IO port unit.
- The IO unit's output-port write strobe and data byte feed a small FIFO; the block serialises bytes onto a single TXD line (8N1, LSB first).
- A status byte goes back to an IO input port so software can poll FIFO and overrun state.

Parameters:
- CLK_DIV, 16, clk cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 4, FIFO entries; power of two, range 2..16.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- wr_en  input  1  one-cycle write strobe from the IO unit (CPU OUTPUT to the UART port)
- wr_data  input  8  byte to enqueue, sampled when wr_en=1
- clr_ovr  input  1  one-cycle pulse; clears the sticky overrun flag
- txd  output  1  serial line, idle high
- status  output  8  {4'b0, overrun, busy, fifo_full, fifo_empty}, registered-state derived
- tx_done  output  1  one-cycle pulse at the end of each stop bit

Behaviour:
- Reset (async, any time, including mid-frame): FIFO emptied, pointers 0, FSM to IDLE, baud counter 0, txd=1, tx_done=0, overrun=0. Status after reset is 8'h01. A partially sent frame is abandoned; the line returns high immediately.
- FIFO write: wr_en=1 and not full → byte stored at the edge.
- wr_en=1 while full → byte dropped and overrun set to 1. This holds even if a pop occurs in the same cycle; fullness is judged on the pre-edge state.
- clr_ovr=1 clears overrun. If clr_ovr and a dropping write coincide, overrun ends at 1 (set wins).
- FSM states: IDLE, START, DATA, STOP.
- IDLE: txd=1. If the FIFO is not empty, pop the head into the shift register, clear the baud counter and bit index, and go to START.
- START: txd=0 for CLK_DIV cycles, then go to DATA.
- DATA: txd=shift[0] for CLK_DIV cycles per bit. Shift right after each bit. After bit index 7, go to STOP.
- STOP: txd=1 for CLK_DIV cycles.
  - At the last cycle, tx_done pulses for 1 cycle.
  - If the FIFO is not empty, pop and go straight to START (back-to-back, no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..CLK_DIV-1; the bit boundary is at count==CLK_DIV-1, then it wraps to 0. Width is $clog2(CLK_DIV).
- txd is a registered output (no glitches).
- Latency: wr_en sampled at edge E0 into an empty FIFO with the FSM idle → pop at E1, txd low from E1. Frame length is exactly 10*CLK_DIV cycles.
- Flags:
  - busy = (state!=IDLE) | !fifo_empty.
  - fifo_full = (count==FIFO_DEPTH).
  - fifo_empty = (count==0).
  - Count width is $clog2(FIFO_DEPTH)+1.
- Simultaneous push and pop on a non-full FIFO: both happen and count is unchanged. On an empty FIFO, the pushed byte is not visible until the next cycle.
- Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro IO_UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. txd = even parity (XOR of the 8 data bits) for CLK_DIV cycles. Frame = 11*CLK_DIV cycles.
- Undefined: no PARITY state, 8N1 framing, 10*CLK_DIV cycle frames.

Decomposition:
- Package io_uart_pkg holds:
  - the FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4);
  - status bit index constants (ST_EMPTY=0, ST_FULL=1, ST_BUSY=2, ST_OVR=3);
  - the line level constants IDLE_LVL=1 and START_LVL=0.
- One sub-module: io_sync_fifo (parameterised width/depth).
  - Ports: push, pop, din, dout (head, combinational), full, empty.
  - Async reset.
- The FSM, baud counter and overrun logic stay in io_uart_tx.

Test Plan:
- Reset then idle 50 cycles → txd=1, status=8'h01, tx_done never pulses.
- CLK_DIV=4, write 8'hA5 → txd from E1: 0, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1. tx_done pulses at cycle 40. Final status=8'h01.
- FIFO_DEPTH=4, write 8'h11,22,33,44,55 on consecutive cycles → 8'h11 is popped on the cycle after it is written, so 8'h55 is still accepted and status=8'h06 (full, busy). A sixth write 8'h66 on the next cycle is dropped and status becomes 8'h0E. Then clr_ovr → bit 3 clears. Frames 11..55 are sent back-to-back with no idle gap, total 50*CLK_DIV cycles.
- Assert reset mid-DATA of frame 8'hFF → txd=1 immediately, FIFO empty, no tx_done. A subsequent write 8'h0F transmits cleanly.
- Overflow with a pop in the same cycle → byte dropped, overrun=1. clr_ovr coincident with a dropping write → overrun stays 1.
- With IO_UART_TX_PARITY_EN, CLK_DIV=2, write 8'h07 → parity bit 1 after data. Frame = 22 cycles, tx_done at cycle 22.
